// File: rtl/nios2_proc_pwm_gen.sv
// nios2_proc_pwm_gen: CHANNELS-wide PWM from one shared up-counter, double-buffered period/compare, Avalon-MM slave.
// Latency: register writes act at the write edge; out_port lags the counter value it is computed from by one cycle.
// Backpressure: none, zero-wait-state slave. Period-end flag/interrupt only when PWM_GEN_IRQ_EN is defined.
module nios2_proc_pwm_gen #(
    parameter int CHANNELS = 6,
    parameter int CNT_W    = 16,
    parameter int ADDR_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [CHANNELS-1:0] out_port,
    output logic                irq
);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_COUNT  = ADDR_W'(3);

    logic             wr;
    logic [CNT_W-1:0] wr_val;
    logic             ctrl_en;
    logic             ctrl_irq_en;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_shd;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] period_shd_nxt;
    logic [CNT_W-1:0] cmp_shd     [CHANNELS];
    logic [CNT_W-1:0] cmp_act     [CHANNELS];
    logic [CNT_W-1:0] cmp_shd_nxt [CHANNELS];
    logic             wrap;
    logic             load_act;
    logic             pf;
    logic             unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign wr_val       = writedata[CNT_W-1:0];
    assign unused_wdata = ^writedata;

    assign wrap     = ctrl_en && (cnt == period_act);
    assign load_act = !ctrl_en || wrap;

    // Shadow values as they will be after this edge, so a write landing on a
    // wrap cycle goes straight into the active registers.
    always_comb begin
        period_shd_nxt = period_shd;
        if (wr && address == A_PERIOD)
            period_shd_nxt = wr_val;
        for (int i = 0; i < CHANNELS; i++) begin
            cmp_shd_nxt[i] = cmp_shd[i];
            if (wr && address == ADDR_W'(i + 4))
                cmp_shd_nxt[i] = wr_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            cnt         <= '0;
            period_shd  <= '0;
            period_act  <= '0;
            out_port    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cmp_shd[i] <= '0;
                cmp_act[i] <= '0;
            end
        end else begin
            if (wr && address == A_CTRL) begin
                ctrl_en     <= writedata[0];
                ctrl_irq_en <= writedata[1];
            end
            period_shd <= period_shd_nxt;
            for (int i = 0; i < CHANNELS; i++)
                cmp_shd[i] <= cmp_shd_nxt[i];
            if (load_act) begin
                period_act <= period_shd_nxt;
                for (int i = 0; i < CHANNELS; i++)
                    cmp_act[i] <= cmp_shd_nxt[i];
            end
            cnt <= (ctrl_en && !wrap) ? cnt + 1'b1 : '0;
            for (int i = 0; i < CHANNELS; i++)
                out_port[i] <= ctrl_en && (cnt < cmp_act[i]);
        end
    end

`ifdef PWM_GEN_IRQ_EN
    // A wrap outranks a simultaneous write-1-to-clear so no period end is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pf <= 1'b0;
        else if (wrap)
            pf <= 1'b1;
        else if (wr && address == A_STATUS && writedata[0])
            pf <= 1'b0;
    end
    assign irq = pf & ctrl_irq_en;
`else
    assign pf  = 1'b0;
    assign irq = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                A_CTRL:   readdata = {30'd0, ctrl_irq_en, ctrl_en};
                A_PERIOD: readdata = 32'(period_shd);
                A_STATUS: readdata = {31'd0, pf};
                A_COUNT:  readdata = 32'(cnt);
                default: begin
                    for (int i = 0; i < CHANNELS; i++)
                        if (address == ADDR_W'(i + 4))
                            readdata = 32'(cmp_shd[i]);
                end
            endcase
        end
    end
endmodule

// File: doc/nios2_proc_pwm_gen.md
# nios2_proc_pwm_gen

Parametrised multi-channel PWM generator with an Avalon-MM slave register interface, sitting on the Nios II system bus in place of a plain software-toggled output port. It drives `CHANNELS` gate-drive lines for the BLDC power stage from one shared up-counter with per-channel compare values. Period and compare writes are double-buffered so that updates take effect only at a period boundary. An optional period-end interrupt paces the commutation and control loop.

## Interface
- `CHANNELS`, 6: number of PWM outputs, 1..(2^`ADDR_W` − 4).
- `CNT_W`, 16: counter, period and compare width, 2..32.
- `ADDR_W`, 4: word address width of the slave.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `address`  in  `ADDR_W`  word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; a write occurs when `chipselect` is high and `write_n` is low.
- `writedata`  in  32  write data.
- `readdata`  out  32  read data, combinational, zero wait states; unused bits read 0.
- `out_port`  out  `CHANNELS`  registered PWM outputs.
- `irq`  out  1  level interrupt.

## Operation
Register map (word addresses):
- 0 CTRL (RW): bit0 `EN`, bit1 `IRQ_EN`.
- 1 PERIOD (RW): shadow period `P`; reads return the shadow value.
- 2 STATUS: bit0 `PF` (period flag). Write 1 to clear; write 0 has no effect.
- 3 COUNT (RO): current counter value.
- 4+i COMPARE[i] (RW), i < `CHANNELS`: shadow compare value; reads return the shadow value.
- Writes to unmapped addresses are ignored. Reads of unmapped addresses return 0.

Counter and outputs:
- `EN` = 1: the counter counts 0..`P_act`, then wraps to 0. The period is `P_act`+1 cycles.
- `EN` = 0: the counter is held at 0, `out_port` = 0, and the active registers copy the shadows every cycle.
- Wrap cycle is defined as `EN` = 1 and `cnt` == `P_act`. In the wrap cycle, `P_act` and all `C_act[i]` load from their shadows. The new values govern from `cnt` = 0 onward.
- `out_port[i]` is registered from `EN` and (`cnt` < `C_act[i]`).
  - `C_act` = 0 gives a constant low output.
  - `C_act` > `P_act` gives a constant high output.
- `P_act` = 0 is legal: every cycle is a wrap cycle.
- A shadow write in the same cycle as a wrap: the active register loads the new write data.
- Arithmetic is unsigned. Only `writedata[CNT_W-1:0]` is used for period and compare writes.

Reset values:
- All registers, shadows, the counter and `PF` reset to 0.
- `out_port` = 0, `irq` = 0, `readdata` = 0 when idle.

## Timing
- CTRL write with `EN` 0→1 at edge k: `cnt` = 0 through edge k+1, then increments. `out_port` first reflects the counter at edge k+1.
- `out_port` lags the `cnt` value it is computed from by one cycle.
- `EN` 1→0: at the next edge `cnt` = 0 and `out_port` = 0.
- Register writes take effect at the clock edge of the write cycle. `readdata` is valid in the same cycle as `address`.
- Reset asserted mid-period: immediate asynchronous clear. Operation resumes only after software sets `EN` again.

## Configuration
`PWM_GEN_IRQ_EN` controls the period-end interrupt.

Defined:
- `PF` is set on each wrap cycle.
- `irq` = `PF` & `IRQ_EN`.
- If a wrap and a write-1-to-clear of `PF` occur in the same cycle, set wins.

Undefined:
- `PF` logic is absent. STATUS reads 0.
- CTRL bit1 is still writable and readable.
- `irq` is tied to 0.

## Test plan
- Reset: assert `reset` mid-run → `out_port` = 0, COUNT reads 0, all registers read 0, `irq` = 0.
- Basic duty: PERIOD = 9, COMPARE[0] = 3, COMPARE[1] = 0, COMPARE[2] = 15, `EN` = 1 → ch0 high 3 of every 10 cycles, ch1 always low, ch2 always high, period 10 cycles.
- Shadowing: mid-period write COMPARE[0] = 7 → the current period keeps duty 3; from the next `cnt` = 0 the duty is 7. Write PERIOD = 4 at the wrap cycle → the next period is 5 cycles.
- Disable: clear `EN` mid-period → next cycle `out_port` = 0 and COUNT = 0. A shadow written while disabled is active on re-enable.
- Degenerate period: PERIOD = 0, COMPARE[0] = 1 → ch0 constant high, COUNT constantly 0. With `PWM_GEN_IRQ_EN`, `PF` is set every cycle.
- Interrupt (with `PWM_GEN_IRQ_EN`): `IRQ_EN` = 1, PERIOD = 9 → `irq` rises one cycle after the wrap cycle. A W1C on STATUS coinciding with a wrap leaves `PF` = 1. A W1C otherwise drops `irq` next cycle. Without the macro, `irq` stays 0 and STATUS reads 0.
